// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter
// Recovers the period and high time of a slow divided clock, counted in
// system-clock cycles. Sits on the debug/observation path next to the clock
// divider so the real divided clock can be confirmed on a display or in sim.
// Also reports whether the ratio is stable (locked) and whether the divided
// clock has stalled long enough to saturate the counter (overflow, sticky).
//
// Timing summary (all relative to clk):
//   - sig_in is synchronized by two flops, then delayed once more to build
//     a rising-edge strobe. The latency is constant, so the measured period
//     and high time are unaffected by it.
//   - The first rise after arming only starts the counters; results appear
//     one cycle after every subsequent rise, as a one-cycle valid pulse.
//   - Every output comes straight from a flop.

module clock_ratio_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  // Counter constants sized to CNT_W so every arithmetic step stays width-clean.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic sync1_q;   // first synchronizer stage, may go metastable
  logic sig_s_q;   // synchronized sig_in
  logic sig_d_q;   // sig_s delayed by one clk, for edge detection
  logic rise;

  // Two-flop synchronizer plus one delay flop for edge detection.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sig_s_q <= 1'b0;
      sig_d_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sig_s_q <= sync1_q;
      sig_d_q <= sig_s_q;
    end
  end

  // Rising edge of the synchronized signal only; the raw input never reaches
  // any decision logic.
  assign rise = sig_s_q & ~sig_d_q;

  // ---------------------------------------------------------------------------
  // Next-value helpers for the counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [CNT_W-1:0] hcnt_inc_d;
  logic             cnt_sat;

  // Increment values for the period and high-time counters.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch can be inferred.
  always_comb begin
    cnt_inc_d  = cnt_q + CNT_ONE;
    hcnt_inc_d = sig_s_q ? (hcnt_q + CNT_ONE) : hcnt_q;
    cnt_sat    = (cnt_q == CNT_MAX);
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             valid_q;
  logic             locked_q;
  logic             overflow_q;

  // Arm on the first rise, then latch period/high time on each later rise.
  // Dropping enable aborts any count from any state; the last published
  // period and high time are kept for display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // valid is a single-cycle strobe; only a rise in MEASURE raises it.
      valid_q <= 1'b0;

      if (!enable) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        hcnt_q     <= '0;
        locked_q   <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Counters stay cleared; arming starts on the next cycle.
            cnt_q   <= '0;
            hcnt_q  <= '0;
            state_q <= WAIT_EDGE;
          end

          WAIT_EDGE: begin
            if (rise) begin
              // The rise cycle itself is the first cycle of the period and
              // the signal is high in it.
              cnt_q   <= CNT_ONE;
              hcnt_q  <= CNT_ONE;
              state_q <= MEASURE;
            end
          end

          MEASURE: begin
            if (rise) begin
              // A rise beats saturation: a period of exactly CNT_MAX is
              // still a legal measurement.
              period_q    <= cnt_q;
              high_time_q <= hcnt_q;
              valid_q     <= 1'b1;
              locked_q    <= (cnt_q == period_q);
              cnt_q       <= CNT_ONE;
              hcnt_q      <= CNT_ONE;
            end else if (cnt_sat) begin
              // Divided clock stalled: flag it and re-arm from the next rise.
              overflow_q <= 1'b1;
              locked_q   <= 1'b0;
              state_q    <= WAIT_EDGE;
            end else begin
              cnt_q  <= cnt_inc_d;
              hcnt_q <= hcnt_inc_d;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench for clock_ratio_meter.
// A free-running generator produces the divided clock from (high, low)
// settings; a timestamp-based reference model predicts every measurement
// and pushes it into a scoreboard queue; a monitor on the falling clk edge
// pops and compares whenever the DUT raises valid, and also compares the
// held status outputs every cycle.

module tb_clock_ratio_meter;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             overflow;

  always #5 clk = ~clk;

  clock_ratio_meter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .enable    (enable),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .overflow  (overflow)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Divided-clock generator: gen_hi cycles high, gen_lo cycles low, repeating.
  // A zero in either setting holds sig_in at stuck_val.
  // ---------------------------------------------------------------------------
  int   gen_hi = 0;
  int   gen_lo = 0;
  logic stuck_val = 1'b0;
  int   phase = 0;

  always @(negedge clk) begin
    if (gen_hi == 0 || gen_lo == 0) begin
      sig_in = stuck_val;
      phase  = 0;
    end else begin
      sig_in = (phase < gen_hi);
      phase  = (phase + 1 >= gen_hi + gen_lo) ? 0 : phase + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // Works from the sampled input history: the measuring logic sees sig_in as
  // it was two samples ago, and a rise is a 0->1 step in that delayed stream.
  // A measurement is the distance between two consecutive armed rises and the
  // number of high samples in between; a gap of CNT_MAX samples with no rise
  // is a stall.
  // ---------------------------------------------------------------------------
  typedef struct {
    int period;
    int high;
    bit locked;
    bit overflow;
  } exp_t;

  typedef enum {M_OFF, M_WAIT, M_ARMED} mmode_e;

  exp_t   exp_q[$];
  mmode_e m_mode;
  logic   p1, p2, p3;       // sig_in samples 1, 2, 3 clk edges ago
  int     t_now;
  int     arm_t;
  int     hsum;
  int     last_p;
  int     last_h;
  bit     locked_m;
  bit     overflow_m;
  logic   s_m;
  logic   rise_m;
  int     n_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode     = M_OFF;
      p1         = 1'b0;
      p2         = 1'b0;
      p3         = 1'b0;
      t_now      = 0;
      arm_t      = 0;
      hsum       = 0;
      last_p     = 0;
      last_h     = 0;
      locked_m   = 1'b0;
      overflow_m = 1'b0;
      exp_q.delete();
    end else begin
      s_m    = p2;
      rise_m = p2 & ~p3;
      if (!enable) begin
        m_mode     = M_OFF;
        locked_m   = 1'b0;
        overflow_m = 1'b0;
      end else begin
        case (m_mode)
          M_OFF: m_mode = M_WAIT;
          M_WAIT: begin
            if (rise_m) begin
              arm_t  = t_now;
              hsum   = 1;
              m_mode = M_ARMED;
            end
          end
          default: begin
            if (rise_m) begin
              n_m = t_now - arm_t;
              exp_q.push_back('{period: n_m, high: hsum,
                                locked: (n_m == last_p), overflow: overflow_m});
              locked_m = (n_m == last_p);
              last_p   = n_m;
              last_h   = hsum;
              arm_t    = t_now;
              hsum     = 1;
            end else if (t_now - arm_t == CNT_MAX) begin
              overflow_m = 1'b1;
              locked_m   = 1'b0;
              m_mode     = M_WAIT;
            end else begin
              hsum += int'(s_m);
            end
          end
        endcase
      end
      p3 = p2;
      p2 = p1;
      p1 = sig_in;
      t_now++;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard on valid, checks held outputs every cycle.
  // ---------------------------------------------------------------------------
  exp_t mon_e;
  bit   mon_exp_valid;

  always @(negedge clk) begin
    mon_exp_valid = (exp_q.size() != 0);
    check("valid_strobe", int'(valid), int'(mon_exp_valid));
    if (mon_exp_valid) begin
      mon_e = exp_q.pop_front();
      if (valid) begin
        check("meas_period",   int'(period),    mon_e.period);
        check("meas_high",     int'(high_time), mon_e.high);
        check("meas_locked",   int'(locked),    int'(mon_e.locked));
        check("meas_overflow", int'(overflow),  int'(mon_e.overflow));
      end
      exp_q.delete();
    end
    check("held_period",   int'(period),    last_p);
    check("held_high",     int'(high_time), last_h);
    check("held_locked",   int'(locked),    int'(locked_m));
    check("held_overflow", int'(overflow),  int'(overflow_m));
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_wave(input int hi, input int lo);
    gen_hi = hi;
    gen_lo = lo;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},   int'(period),    0);
    check({tag, "_high"},     int'(high_time), 0);
    check({tag, "_valid"},    int'(valid),     0);
    check({tag, "_locked"},   int'(locked),    0);
    check({tag, "_overflow"}, int'(overflow),  0);
  endtask

  initial begin
    // Reset state.
    cycles(3);
    check_all_zero("reset");
    rst_n  = 1'b1;
    enable = 1'b1;

    // Ratio 10, high 5: settles to period 10, high 5, locked.
    set_wave(5, 5);
    cycles(60);
    check("s1_period", int'(period), 10);
    check("s1_high",   int'(high_time), 5);
    check("s1_locked", int'(locked), 1);

    // Switch to ratio 6, high 3.
    set_wave(3, 3);
    cycles(40);
    check("s2_period", int'(period), 6);
    check("s2_high",   int'(high_time), 3);
    check("s2_locked", int'(locked), 1);

    // Stall high long enough to saturate the counter.
    set_wave(0, 0);
    stuck_val = 1'b0;
    cycles(6);
    stuck_val = 1'b1;
    cycles(25);
    check("s3_overflow", int'(overflow), 1);
    check("s3_locked",   int'(locked), 0);

    // Recover with an 8-cycle clock; overflow stays sticky.
    set_wave(4, 4);
    cycles(40);
    check("s3_period",      int'(period), 8);
    check("s3_overflow_st", int'(overflow), 1);

    // Drop enable mid-run: flags clear, period held.
    set_wave(5, 5);
    cycles(54);
    enable = 1'b0;
    cycles(3);
    check("s4_locked",   int'(locked), 0);
    check("s4_overflow", int'(overflow), 0);
    check("s4_period",   int'(period), 10);
    enable = 1'b1;
    cycles(50);
    check("s4_period_re", int'(period), 10);

    // Asynchronous reset between clock edges.
    cycles(13);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    cycles(3);
    rst_n = 1'b1;
    cycles(60);
    check("s5_period", int'(period), 10);
    check("s5_high",   int'(high_time), 5);
    check("s5_locked", int'(locked), 1);

    // Minimum period of 2.
    set_wave(1, 1);
    cycles(30);
    check("s6_period", int'(period), 2);
    check("s6_high",   int'(high_time), 1);
    check("s6_locked", int'(locked), 1);

    // Boundary: period exactly CNT_MAX is still measured, no overflow.
    set_wave(8, 7);
    cycles(70);
    check("sat_period",   int'(period), CNT_MAX);
    check("sat_overflow", int'(overflow), 0);

    // Randomized ratios (including stalls at 16) and enable drops.
    for (int i = 0; i < 20; i++) begin
      set_wave($urandom_range(1, 8), $urandom_range(1, 8));
      cycles($urandom_range(30, 70));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        cycles($urandom_range(1, 4));
        enable = 1'b1;
      end
    end

    cycles(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
